freq_sel_detect: RTL and testbench

//  Measures the half-period of a square-wave input and recovers the 2-bit rate select

---
 rtl/freq_sel_detect_pkg.sv | 22 ++
 rtl/freq_sel_detect_sync_edge.sv | 37 +++
 rtl/freq_sel_detect.sv | 145 ++++++++++++++
 tb/tb_freq_sel_detect.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/freq_sel_detect_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | freq_pkg : rate-select constants, code type and detector FSM states       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package freq_pkg;

    // Half-periods in clk cycles at 50 MHz; shared with the select/divider side.
    localparam int unsigned HP0_DEF = 25_000_000;
    localparam int unsigned HP1_DEF = 12_500_000;
    localparam int unsigned HP2_DEF = 8_333_333;
    localparam int unsigned HP3_DEF = 6_250_000;

    typedef logic [1:0] rate_code_t;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

endpackage : freq_pkg
`default_nettype wire

// File: rtl/freq_sel_detect_sync_edge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_edge : 2-flop synchronizer plus any-edge pulse from a third flop     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic pulse
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = d_async;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign pulse = s2_q ^ s3_q;

endmodule : sync_edge
`default_nettype wire

// File: rtl/freq_sel_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | freq_sel_detect : measures sig_in half-period and recovers the rate code  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module freq_sel_detect
    import freq_pkg::*;
#(
    parameter int unsigned HP0     = HP0_DEF,
    parameter int unsigned HP1     = HP1_DEF,
    parameter int unsigned HP2     = HP2_DEF,
    parameter int unsigned HP3     = HP3_DEF,
    parameter int unsigned LOCK_N  = 3,
    parameter int unsigned TIMEOUT = 2 * HP0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sig_in,
    output logic [1:0]  sel,
    output logic [31:0] period,
    output logic        valid,
    output logic        lock
);

    // Band boundaries are integer midpoints between neighbouring half-periods.
    localparam logic [31:0] c_top     = 32'((3 * HP0) / 2);
    localparam logic [31:0] c_b0      = 32'((HP0 + HP1) / 2);
    localparam logic [31:0] c_b1      = 32'((HP1 + HP2) / 2);
    localparam logic [31:0] c_b2      = 32'((HP2 + HP3) / 2);
    localparam logic [31:0] c_low     = 32'(HP3 / 2);
    localparam logic [31:0] c_timeout = 32'(TIMEOUT);
    localparam logic [31:0] c_lock    = 32'(LOCK_N);

    logic        w_pulse;
    rate_code_t  w_code;
    logic        w_inband;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] match_q, match_d;
    rate_code_t  sel_q, sel_d;
    logic [31:0] period_q, period_d;
    logic        valid_q, valid_d;
    logic        lock_q, lock_d;

    sync_edge u_sync_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_async (sig_in),
        .pulse   (w_pulse)
    );

    always_comb begin
        w_code   = 2'b00;
        w_inband = 1'b1;
        if (cnt_q >= c_b0 && cnt_q < c_top) begin
            w_code = 2'b00;
        end else if (cnt_q >= c_b1 && cnt_q < c_b0) begin
            w_code = 2'b01;
        end else if (cnt_q >= c_b2 && cnt_q < c_b1) begin
            w_code = 2'b10;
        end else if (cnt_q >= c_low && cnt_q < c_b2) begin
            w_code = 2'b11;
        end else begin
            w_inband = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        match_d  = match_q;
        sel_d    = sel_q;
        period_d = period_q;
        valid_d  = valid_q;
        lock_d   = lock_q;

        // cnt restarts at 1 on a pulse so that it reads the exact pulse spacing.
        if (w_pulse) begin
            cnt_d = 32'd1;
        end else if (cnt_q < c_timeout) begin
            cnt_d = cnt_q + 32'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_pulse) begin
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                // A pulse coinciding with the timeout still yields a result.
                if (w_pulse) begin
                    period_d = cnt_q;
                    if (w_inband) begin
                        valid_d = 1'b1;
                        sel_d   = w_code;
                        if (w_code == sel_q && match_q != 32'd0) begin
                            match_d = (match_q >= c_lock) ? c_lock : match_q + 32'd1;
                        end else begin
                            match_d = 32'd1;
                        end
                    end else begin
                        valid_d = 1'b0;
                        match_d = 32'd0;
                    end
                    lock_d = (match_d == c_lock);
                end else if (cnt_q >= c_timeout) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    lock_d  = 1'b0;
                    match_d = 32'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 32'd0;
            match_q  <= 32'd0;
            sel_q    <= 2'b00;
            period_q <= 32'd0;
            valid_q  <= 1'b0;
            lock_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            match_q  <= match_d;
            sel_q    <= sel_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            lock_q   <= lock_d;
        end
    end

    assign sel    = sel_q;
    assign period = period_q;
    assign valid  = valid_q;
    assign lock   = lock_q;

endmodule : freq_sel_detect
`default_nettype wire

// File: tb/tb_freq_sel_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_freq_sel_detect : directed + randomized bench with a behavioural model |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_freq_sel_detect;

    localparam int HP0     = 100;
    localparam int HP1     = 50;
    localparam int HP2     = 33;
    localparam int HP3     = 25;
    localparam int LOCK_N  = 3;
    localparam int TIMEOUT = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sig_in = 1'b0;
    logic [1:0]  sel;
    logic [31:0] period;
    logic        valid;
    logic        lock;

    int checks = 0;
    int failures = 0;

    // Behavioural model state: whether a reference edge exists, the visible
    // outputs, and how many consecutive in-band results shared one code.
    bit m_armed = 1'b0;
    int m_sel = 0;
    int m_period = 0;
    bit m_valid = 1'b0;
    bit m_lock = 1'b0;
    int m_streak = 0;
    int prev_gap = 0;

    freq_sel_detect #(
        .HP0     (HP0),
        .HP1     (HP1),
        .HP2     (HP2),
        .HP3     (HP3),
        .LOCK_N  (LOCK_N),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .sel    (sel),
        .period (period),
        .valid  (valid),
        .lock   (lock)
    );

    always #5 clk = ~clk;

    // Returns the rate code whose band contains p, or -1 when out of band.
    function automatic int band(input int p);
        int bounds[5];
        bounds = '{(3 * HP0) / 2, (HP0 + HP1) / 2, (HP1 + HP2) / 2, (HP2 + HP3) / 2, HP3 / 2};
        for (int k = 0; k < 4; k++) begin
            if (p < bounds[k] && p >= bounds[k + 1]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_armed  = 1'b0;
        m_sel    = 0;
        m_period = 0;
        m_valid  = 1'b0;
        m_lock   = 1'b0;
        m_streak = 0;
    endtask

    task automatic model_edge(input int gap);
        int k;
        if (!m_armed) begin
            m_armed = 1'b1;
        end else begin
            m_period = gap;
            k = band(gap);
            if (k >= 0) begin
                m_streak = (k == m_sel && m_streak > 0) ? m_streak + 1 : 1;
                m_sel    = k;
                m_valid  = 1'b1;
            end else begin
                m_streak = 0;
                m_valid  = 1'b0;
            end
            m_lock = (m_streak >= LOCK_N);
        end
    endtask

    task automatic check_all(input string tag);
        logic [1:0]  e_sel;
        logic [31:0] e_period;
        e_sel    = 2'(m_sel);
        e_period = 32'(m_period);
        checks++;
        assert (sel === e_sel) else begin
            failures++;
            $error("FAIL %s.sel observed=%0d expected=%0d", tag, sel, e_sel);
        end
        checks++;
        assert (period === e_period) else begin
            failures++;
            $error("FAIL %s.period observed=%0d expected=%0d", tag, period, e_period);
        end
        checks++;
        assert (valid === m_valid) else begin
            failures++;
            $error("FAIL %s.valid observed=%0b expected=%0b", tag, valid, m_valid);
        end
        checks++;
        assert (lock === m_lock) else begin
            failures++;
            $error("FAIL %s.lock observed=%0b expected=%0b", tag, lock, m_lock);
        end
    endtask

    // Toggle sig_in now (caller sits on a falling clk edge), then hold for n cycles.
    task automatic edge_wait(input int n, input bit chk, input string tag);
        sig_in = ~sig_in;
        model_edge(prev_gap);
        repeat (n) @(negedge clk);
        prev_gap = n;
        if (n > TIMEOUT) begin
            m_armed  = 1'b0;
            m_valid  = 1'b0;
            m_lock   = 1'b0;
            m_streak = 0;
        end
        if (chk) check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n  = 1'b0;
        sig_in = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int g;
        // Power-on reset.
        #1;
        check_all("por");
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Steady 50-cycle half-period: first edge only arms, lock on 3rd result.
        for (int i = 0; i < 6; i++) edge_wait(50, 1'b1, "hp50");

        // Reset in the middle of a count.
        edge_wait(20, 1'b0, "mid");
        do_reset("rst_mid");
        edge_wait(50, 1'b1, "rearm");
        edge_wait(50, 1'b1, "first_after_rst");

        // Rate change 50 -> 25.
        for (int i = 0; i < 3; i++) edge_wait(50, 1'b1, "pre_switch");
        for (int i = 0; i < 4; i++) edge_wait(25, 1'b1, "hp25");

        // Band edges.
        edge_wait(75, 1'b1, "b75");
        edge_wait(74, 1'b1, "b74");
        edge_wait(150, 1'b1, "b150");
        edge_wait(11, 1'b1, "b11");
        edge_wait(74, 1'b1, "b74_again");

        // Lock then stop toggling past the timeout.
        for (int i = 0; i < 4; i++) edge_wait(50, 1'b1, "pre_timeout");
        edge_wait(230, 1'b1, "timeout");
        edge_wait(50, 1'b1, "rearm_to");
        edge_wait(50, 1'b1, "fresh_to");

        // Edge landing exactly on the timeout still yields a result.
        edge_wait(200, 1'b1, "exact_to");

        // One-cycle glitch inside a 50-cycle half-period.
        for (int i = 0; i < 3; i++) edge_wait(50, 1'b1, "pre_glitch");
        edge_wait(5, 1'b0, "gl_a");
        edge_wait(1, 1'b0, "gl_b");
        edge_wait(44, 1'b1, "gl_c");
        for (int i = 0; i < 4; i++) edge_wait(50, 1'b1, "recover");

        // Randomized half-periods.
        for (int i = 0; i < 50; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: g = 50;
                4, 5:       g = 25;
                6:          g = 33;
                7:          g = 100;
                8:          g = int'($urandom_range(5, 160));
                default:    g = 230;
            endcase
            edge_wait(g, 1'b1, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_freq_sel_detect
`default_nettype wire
